seg_shift_display_driver: RTL and testbench
===========================================

Name: seg_shift_display_driver

Overview:
Parametrised successor to the calculator's 7-segment shift-register output driver. It accepts a magnitude, sign flag and error flag over a valid/ready handshake. It renders the value as decimal (sequential double-dabble) or hexadecimal, with leading-zero blanking, a minus sign and "Err" display, and selectable common-anode or common-cathode polarity. It then serialises NUM_DIGITS segment bytes to an external shift-register chain and pulses the latch.

Parameters:
DATA_WIDTH, 16, width of i_data (unsigned magnitude)
NUM_DIGITS, 5, number of 7-segment digits in the chain (must be at least 2)
CLK_DIV, 2, clk cycles per o_sr_clk half-period and per latch pulse (must be at least 1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_data  input  DATA_WIDTH  magnitude to display
i_data_is_neg  input  1  show minus sign
i_error  input  1  show "Err" instead of the value
i_hex_mode  input  1  1 = hex, 0 = decimal
i_common_anode  input  1  1 = invert all segment bits
i_valid  input  1  transaction valid
o_ready  output  1  block idle, can accept
o_sr_data  output  1  serial segment data
o_sr_clk  output  1  shift clock to the chain
o_sr_latch  output  1  storage-register latch pulse
o_sr_oe_n  output  1  chain output enable, active low
o_busy  output  1  equal to ~o_ready

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset, asserted at any time including mid-operation, forces state IDLE, o_ready=1, o_busy=0, o_sr_data=0, o_sr_clk=0, o_sr_latch=0, o_sr_oe_n=1. All internal registers are cleared.
- Handshake: a transaction is accepted when i_valid && o_ready. All inputs, including the mode pins, are registered at accept. Input changes after accept have no effect. i_valid while busy is ignored.
- FSM transitions:
  - IDLE goes to CONVERT on accept.
  - CONVERT goes to SHIFT when conversion is done.
  - SHIFT goes to LATCH after the last bit.
  - LATCH goes to IDLE.
- CONVERT, decimal mode:
  - Double-dabble runs 1 bit per cycle, DATA_WIDTH cycles.
  - The BCD register is wide enough for the full DATA_WIDTH.
- CONVERT, hex mode: 1 cycle, nibble split.
- Digit formation:
  - Digit 0 is the least significant.
  - Leading zeros are blanked, but digit 0 always shows (0 shows "0").
  - A minus sign (0x40) is placed one digit left of the most significant shown digit.
- Overflow: if significant digits (plus the sign, if negative) exceed NUM_DIGITS, the block displays the error pattern.
- Error pattern: digits 2,1,0 = E,r,r (0x79,0x50,0x50); all other digits blank. This pattern is used for i_error=1 and for overflow.
- Segment byte = {dp,g,f,e,d,c,b,a}; dp is always 0. Common-cathode codes:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
  - A:77 b:7C C:39 d:5E E:79 F:71
  - blank:00
  - If common anode is selected, the entire byte is inverted.
- SHIFT order: digit NUM_DIGITS-1 first, bit 7 first within each byte; 8*NUM_DIGITS bits total.
- Per-bit timing: o_sr_data changes while o_sr_clk is low. o_sr_clk is low for CLK_DIV cycles, then high for CLK_DIV cycles; the rising edge is mid-bit. o_sr_clk is 0 outside SHIFT.
- LATCH: o_sr_latch=1 for CLK_DIV cycles, after which o_sr_data returns to 0.
- o_sr_oe_n stays 1 from reset until the first LATCH completes, then remains 0 until the next reset.
- Busy duration from the accept edge until o_ready=1: C + 16*NUM_DIGITS*CLK_DIV + CLK_DIV, where C = DATA_WIDTH (decimal) or 1 (hex).
  - With defaults: 178 cycles decimal, 163 cycles hex.
- Back-to-back: a new transaction may be accepted in the first cycle o_ready=1.

Test Plan:
1. Decimal, CC, i_data=1234, positive: bytes 00,06,5B,4F,66; exactly 40 o_sr_clk rising edges; one 2-cycle latch pulse; o_ready rises 178 cycles after accept; o_sr_oe_n falls after the latch.
2. Decimal, i_data=65535: bytes 7D,6D,6D,4F,6D. Same value with i_data_is_neg=1 overflows: bytes 00,00,79,50,50.
3. Decimal, negative 42: bytes 00,00,40,66,5B. i_data=0 positive: bytes 00,00,00,00,3F.
4. Hex, common anode, i_data=0xBEEF: bytes FF,83,86,86,8E (CC equivalent 00,7C,79,79,71); busy lasts 163 cycles.
5. i_error=1 with i_data=7: bytes 00,00,79,50,50. Toggle i_data and the mode pins mid-SHIFT: the output stream is unchanged. i_valid held high while busy: no second accept until o_ready.
6. Assert rst_n low during SHIFT: all outputs take reset values asynchronously and o_sr_oe_n returns to 1. After release, a decimal 7 transaction produces bytes 00,00,00,00,07 correctly.

Source files
------------

// File: rtl/seg_shift_display_driver_if.sv
// Request-side bundle for seg_shift_display_driver: value, display flags and
// the valid/ready handshake with its busy companion.
interface seg_shift_display_driver_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_data_is_neg;
   logic                  i_error;
   logic                  i_hex_mode;
   logic                  i_common_anode;
   logic                  i_valid;
   logic                  o_ready;
   logic                  o_busy;

   modport master (
      output i_data, i_data_is_neg, i_error, i_hex_mode, i_common_anode, i_valid,
      input  o_ready, o_busy
   );

   modport slave (
      input  i_data, i_data_is_neg, i_error, i_hex_mode, i_common_anode, i_valid,
      output o_ready, o_busy
   );
endinterface

// File: rtl/seg_shift_display_driver.sv
// 7-segment shift-register driver: converts a magnitude to decimal or hex digits,
// formats sign/blanking/"Err", then serialises the segment bytes and latches them.
module seg_shift_display_driver #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_DIGITS = 5,
   parameter int CLK_DIV    = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   seg_shift_display_driver_if.slave    bus,
   output logic                         o_sr_data,
   output logic                         o_sr_clk,
   output logic                         o_sr_latch,
   output logic                         o_sr_oe_n
);

   // Decimal digit count of 2^DATA_WIDTH-1, via log10(2) ~= 0.30103 (never underestimates).
   localparam int DEC_D  = (DATA_WIDTH * 30103) / 100000 + 1;
   localparam int HEX_D  = (DATA_WIDTH + 3) / 4;
   localparam int MAX_DH = (DEC_D > HEX_D) ? DEC_D : HEX_D;
   localparam int MAXD   = (MAX_DH > NUM_DIGITS) ? MAX_DH : NUM_DIGITS;
   localparam int BCD_W  = 4 * DEC_D;
   localparam int HEX_W  = 4 * HEX_D;
   localparam int NBITS  = 8 * NUM_DIGITS;
   localparam int CNTW   = $clog2(DATA_WIDTH + 1);
   localparam int BITW   = $clog2(NBITS);
   localparam int DIVW   = $clog2(CLK_DIV + 1);

   localparam logic [CNTW-1:0] CONV_LAST = CNTW'(DATA_WIDTH - 1);
   localparam logic [BITW-1:0] BIT_LAST  = BITW'(NBITS - 1);
   localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONVERT,
      S_SHIFT,
      S_LATCH
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [DATA_WIDTH-1:0] r_data;
   logic                 r_neg;
   logic                 r_err;
   logic                 r_hex;
   logic                 r_ca;
   logic [BCD_W-1:0]     r_bcd;
   logic [CNTW-1:0]      r_cnt;
   logic [NBITS-1:0]     r_shift;
   logic [DIVW-1:0]      r_div;
   logic                 r_hi;
   logic [BITW-1:0]      r_bit;
   logic                 r_sr_data;
   logic                 r_sr_clk;
   logic                 r_sr_latch;
   logic                 r_sr_oe_n;

   logic                 w_accept;
   logic                 w_tick;
   logic                 w_conv_done;
   logic [BCD_W-1:0]     w_bcd_adj;
   logic [BCD_W-1:0]     w_bcd_next;
   logic [HEX_W-1:0]     w_hex_pad;
   logic [4*MAXD-1:0]    w_digits;
   int                   w_nsig;
   logic                 w_ovf;
   logic [NBITS-1:0]     w_fmt;

   function automatic logic [7:0] seg7(input logic [3:0] v);
      case (v)
         4'h0: seg7 = 8'h3F;  4'h1: seg7 = 8'h06;  4'h2: seg7 = 8'h5B;  4'h3: seg7 = 8'h4F;
         4'h4: seg7 = 8'h66;  4'h5: seg7 = 8'h6D;  4'h6: seg7 = 8'h7D;  4'h7: seg7 = 8'h07;
         4'h8: seg7 = 8'h7F;  4'h9: seg7 = 8'h6F;  4'hA: seg7 = 8'h77;  4'hB: seg7 = 8'h7C;
         4'hC: seg7 = 8'h39;  4'hD: seg7 = 8'h5E;  4'hE: seg7 = 8'h79;  default: seg7 = 8'h71;
      endcase
   endfunction

   assign w_accept    = bus.i_valid && (r_state == S_IDLE);
   assign w_tick      = (r_div == DIV_LAST);
   assign w_conv_done = r_hex || (r_cnt == CONV_LAST);
   assign w_hex_pad   = HEX_W'(r_data);

   assign bus.o_ready = (r_state == S_IDLE);
   assign bus.o_busy  = (r_state != S_IDLE);
   assign o_sr_data   = r_sr_data;
   assign o_sr_clk    = r_sr_clk;
   assign o_sr_latch  = r_sr_latch;
   assign o_sr_oe_n   = r_sr_oe_n;

   // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next data MSB.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_bcd_adj = r_bcd;
      for (int d = 0; d < DEC_D; d++) begin
         if (r_bcd[4*d +: 4] > 4'd4) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
      w_bcd_next = (w_bcd_adj << 1) | BCD_W'(r_data[DATA_WIDTH-1]);
   end

   // Decimal digits are taken from the step in flight so the last step loads the shifter directly.
   always_comb begin
      w_digits = '0;
      if (r_hex) w_digits[HEX_W-1:0] = w_hex_pad;
      else       w_digits[BCD_W-1:0] = w_bcd_next;
   end

   always_comb begin
      w_nsig = 1;
      for (int i = 0; i < MAXD; i++) begin
         if (w_digits[4*i +: 4] != 4'h0) w_nsig = i + 1;
      end
      w_ovf = (w_nsig + (r_neg ? 1 : 0)) > NUM_DIGITS;
   end

   always_comb begin
      logic [7:0] v_byte;
      w_fmt = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         v_byte = 8'h00;
         if (r_err || w_ovf) begin
            if (k == 2)     v_byte = 8'h79;
            else if (k < 2) v_byte = 8'h50;
         end else if (k < w_nsig) begin
            v_byte = seg7(w_digits[4*k +: 4]);
         end else if (r_neg && (k == w_nsig)) begin
            v_byte = 8'h40;
         end
         if (r_ca) v_byte = ~v_byte;
         w_fmt[8*k +: 8] = v_byte;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_state_next = S_CONVERT;
         S_CONVERT: if (w_conv_done) w_state_next = S_SHIFT;
         S_SHIFT:   if (w_tick && r_hi && (r_bit == BIT_LAST)) w_state_next = S_LATCH;
         S_LATCH:   if (w_tick) w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data     <= '0;
         r_neg      <= 1'b0;
         r_err      <= 1'b0;
         r_hex      <= 1'b0;
         r_ca       <= 1'b0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_div      <= '0;
         r_hi       <= 1'b0;
         r_bit      <= '0;
         r_sr_data  <= 1'b0;
         r_sr_clk   <= 1'b0;
         r_sr_latch <= 1'b0;
         r_sr_oe_n  <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_data <= bus.i_data;
                  r_neg  <= bus.i_data_is_neg;
                  r_err  <= bus.i_error;
                  r_hex  <= bus.i_hex_mode;
                  r_ca   <= bus.i_common_anode;
                  r_bcd  <= '0;
                  r_cnt  <= '0;
               end
            end
            S_CONVERT: begin
               if (!r_hex) begin
                  r_bcd  <= w_bcd_next;
                  r_data <= r_data << 1;
                  r_cnt  <= r_cnt + 1'b1;
               end
               if (w_conv_done) begin
                  r_shift   <= w_fmt;
                  r_sr_data <= w_fmt[NBITS-1];
                  r_sr_clk  <= 1'b0;
                  r_div     <= '0;
                  r_hi      <= 1'b0;
                  r_bit     <= '0;
               end
            end
            S_SHIFT: begin
               r_div <= w_tick ? '0 : r_div + 1'b1;
               if (w_tick) begin
                  if (!r_hi) begin
                     r_sr_clk <= 1'b1;
                     r_hi     <= 1'b1;
                  end else begin
                     r_sr_clk <= 1'b0;
                     r_hi     <= 1'b0;
                     if (r_bit == BIT_LAST) begin
                        r_sr_latch <= 1'b1;
                     end else begin
                        r_shift   <= r_shift << 1;
                        r_sr_data <= r_shift[NBITS-2];
                        r_bit     <= r_bit + 1'b1;
                     end
                  end
               end
            end
            S_LATCH: begin
               r_div <= w_tick ? '0 : r_div + 1'b1;
               if (w_tick) begin
                  r_sr_latch <= 1'b0;
                  r_sr_data  <= 1'b0;
                  r_sr_oe_n  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_shift_display_driver.sv
// Scoreboard bench for seg_shift_display_driver: expected segment streams come from
// an arithmetic reference model; a negedge monitor reassembles the serial stream.
module tb_seg_shift_display_driver;

   localparam int DW = 16;
   localparam int ND = 5;
   localparam int CD = 2;
   localparam int NB = 8 * ND;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic o_sr_data, o_sr_clk, o_sr_latch, o_sr_oe_n;

   always #5 clk = ~clk;

   seg_shift_display_driver_if #(.DATA_WIDTH(DW)) bus ();

   seg_shift_display_driver #(
      .DATA_WIDTH(DW),
      .NUM_DIGITS(ND),
      .CLK_DIV   (CD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .o_sr_data (o_sr_data),
      .o_sr_clk  (o_sr_clk),
      .o_sr_latch(o_sr_latch),
      .o_sr_oe_n (o_sr_oe_n)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   logic [NB-1:0] exp_q[$];
   logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Digits by repeated division; byte k of the result is digit k.
   function automatic logic [NB-1:0] model(input logic [DW-1:0] v, input bit neg, input bit err,
                                           input bit hex, input bit ca);
      int digs[$];
      longint unsigned x = longint'(v);
      longint unsigned base = hex ? 16 : 10;
      logic [NB-1:0] w = '0;
      logic [7:0] b;
      do begin
         digs.push_back(int'(x % base));
         x = x / base;
      end while (x != 0);
      for (int k = 0; k < ND; k++) begin
         b = 8'h00;
         if (err || (digs.size() + (neg ? 1 : 0) > ND)) b = (k == 2) ? 8'h79 : (k < 2) ? 8'h50 : 8'h00;
         else if (k < digs.size()) b = seg_tab[digs[k]];
         else if (neg && k == digs.size()) b = 8'h40;
         if (ca) b = ~b;
         w[8*k +: 8] = b;
      end
      return w;
   endfunction

   // Monitor: capture data on each o_sr_clk rise, compare at each latch rise.
   int nbits;
   int lat_w;
   logic [NB-1:0] cap;
   logic prev_clk, prev_latch;
   bit exp_oe_n;
   always @(negedge clk) begin
      if (!rst_n) begin
         nbits = 0; lat_w = 0; cap = '0;
         prev_clk = 1'b0; prev_latch = 1'b0; exp_oe_n = 1'b1;
      end else begin
         if (o_sr_clk && !prev_clk) begin
            cap = {cap[NB-2:0], o_sr_data};
            nbits++;
         end
         if (o_sr_latch) lat_w++;
         if (o_sr_latch && !prev_latch) begin
            check("bit_count", nbits, NB);
            check("oe_n_at_latch", o_sr_oe_n, exp_oe_n);
            check("latch_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("stream", cap, exp_q.pop_front());
            nbits = 0;
         end
         if (!o_sr_latch && prev_latch) begin
            check("latch_width", lat_w, CD);
            check("data_after_latch", o_sr_data, 0);
            check("oe_n_after_latch", o_sr_oe_n, 0);
            exp_oe_n = 1'b0;
            lat_w = 0;
         end
         prev_clk = o_sr_clk;
         prev_latch = o_sr_latch;
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (!bus.o_ready && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      check("ready_wait", bus.o_ready, 1);
   endtask

   task automatic send(input logic [DW-1:0] v, input bit neg, input bit err, input bit hex,
                       input bit ca, input bit hold_valid);
      int cyc = 0;
      wait_ready();
      @(negedge clk);
      bus.i_data = v; bus.i_data_is_neg = neg; bus.i_error = err;
      bus.i_hex_mode = hex; bus.i_common_anode = ca; bus.i_valid = 1'b1;
      exp_q.push_back(model(v, neg, err, hex, ca));
      @(posedge clk); #1;
      if (!hold_valid) bus.i_valid = 1'b0;
      while (!bus.o_ready && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
      end
      bus.i_valid = 1'b0;
      check("busy_cycles", cyc, (hex ? 1 : DW) + 16 * ND * CD + CD);
   endtask

   initial begin
      bus.i_data = '0; bus.i_data_is_neg = 1'b0; bus.i_error = 1'b0;
      bus.i_hex_mode = 1'b0; bus.i_common_anode = 1'b0; bus.i_valid = 1'b0;
      #12;
      check("rst_ready", bus.o_ready, 1);
      check("rst_busy", bus.o_busy, 0);
      check("rst_sr_clk", o_sr_clk, 0);
      check("rst_latch", o_sr_latch, 0);
      check("rst_data", o_sr_data, 0);
      check("rst_oe_n", o_sr_oe_n, 1);
      @(negedge clk); rst_n = 1'b1;

      send(16'd1234, 0, 0, 0, 0, 0);
      check("oe_n_after_first", o_sr_oe_n, 0);
      send(16'd65535, 0, 0, 0, 0, 0);
      send(16'd65535, 1, 0, 0, 0, 0);
      send(16'd42, 1, 0, 0, 0, 0);
      send(16'd0, 0, 0, 0, 0, 0);
      send(16'hBEEF, 0, 0, 1, 1, 0);

      // Input changes during SHIFT must not disturb the stream.
      fork
         send(16'd7, 0, 1, 0, 0, 0);
         begin
            repeat (60) @(negedge clk);
            repeat (60) begin
               @(negedge clk);
               bus.i_data = DW'($urandom);
               bus.i_data_is_neg = 1'($urandom);
               bus.i_error = 1'($urandom);
               bus.i_hex_mode = 1'($urandom);
               bus.i_common_anode = 1'($urandom);
            end
         end
      join
      send(16'd1234, 0, 0, 0, 0, 1);
      repeat (4) @(posedge clk);
      #1 check("no_reaccept_ready", bus.o_ready, 1);

      for (int n = 0; n < 20; n++) begin
         logic [DW-1:0] v;
         v = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 99)) : DW'($urandom);
         send(v, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end

      // Reset in the middle of SHIFT.
      wait_ready();
      @(negedge clk);
      bus.i_data = 16'd1234; bus.i_data_is_neg = 1'b0; bus.i_error = 1'b0;
      bus.i_hex_mode = 1'b0; bus.i_common_anode = 1'b0; bus.i_valid = 1'b1;
      @(posedge clk); #1 bus.i_valid = 1'b0;
      repeat (60) @(posedge clk);
      #3;
      check("pre_rst_oe_n", o_sr_oe_n, 0);
      check("pre_rst_busy", bus.o_busy, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_ready", bus.o_ready, 1);
      check("async_rst_busy", bus.o_busy, 0);
      check("async_rst_data", o_sr_data, 0);
      check("async_rst_sr_clk", o_sr_clk, 0);
      check("async_rst_latch", o_sr_latch, 0);
      check("async_rst_oe_n", o_sr_oe_n, 1);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(16'd7, 0, 0, 0, 0, 0);

      repeat (10) @(posedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
